// File: rtl/sub_bytes_seq.sv
// Sequential AES SubBytes: one 128-bit state is substituted in place,
// BYTES_PER_CYCLE bytes per cycle, then held until downstream accepts it.

module s_box (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Row r of the table holds S(16r) .. S(16r+15), first entry in the MSBs.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX_TABLE[11'd2047 - {a, 3'b000} -: 8];
endmodule

module sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);
  if (!(BYTES_PER_CYCLE inside {32'sd1, 32'sd2, 32'sd4, 32'sd8, 32'sd16})) begin : g_bad_bpc
    $error("sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // A step of 16 truncates to 0, which is exactly the required wrap of idx.
  localparam logic [3:0] STEP     = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] LAST_IDX = 4'(32'sd16 - BYTES_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [3:0]     idx_r, idx_s;
  logic [127:0]   work_r, work_s;
  logic [7:0]     sb_in_s  [BYTES_PER_CYCLE];
  logic [7:0]     sb_out_s [BYTES_PER_CYCLE];

  for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
    logic [3:0] pos_s;
    assign pos_s      = idx_r + 4'(k);
    assign sb_in_s[k] = work_r[7'd127 - {pos_s, 3'b000} -: 8];
    s_box u_s_box (
      .a (sb_in_s[k]),
      .y (sb_out_s[k])
    );
  end

  // Next-state, index and working-register update.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    work_s  = work_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          work_s  = in_data;
          idx_s   = 4'd0;
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
          work_s[7'd127 - {idx_r + 4'(k), 3'b000} -: 8] = sb_out_s[k];
        end
        idx_s = idx_r + STEP;
        if (idx_r == LAST_IDX) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 4'd0;
        work_s  = 128'h0;
      end
    endcase
  end

  // State, index and working register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= 4'd0;
      work_r  <= 128'h0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      work_r  <= work_s;
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_data  = work_r;
endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench: one sub_bytes_seq per legal BYTES_PER_CYCLE on shared inputs, checked
// against an S-box derived from GF(2^8) inversion plus the affine map.

module tb_sub_bytes_seq;
  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         ir [5];
  logic         ov [5];
  logic         bz [5];
  logic [127:0] od [5];

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sbox_tab [256];

  for (genvar j = 0; j < 5; j++) begin : g_dut
    sub_bytes_seq #(.BYTES_PER_CYCLE(1 << j)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (ir[j]),
      .in_data   (in_data),
      .out_valid (ov[j]),
      .out_ready (out_ready),
      .out_data  (od[j]),
      .busy      (bz[j])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_math(input logic [7:0] v);
    logic [7:0] inv, b;
    inv = 8'h00;
    for (int c = 1; c < 256; c++) begin
      if (gmul(v, 8'(c)) == 8'h01) inv = 8'(c);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_sub(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox_tab[s[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_all();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Feed one state to every instance, check out_valid timing per cycle and the result.
  task automatic run_all(input string name, input logic [127:0] v, input logic [127:0] exp);
    in_valid = 1'b1; in_data = v; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; in_data = rnd128();
    for (int c = 1; c <= 16; c++) begin
      tick();
      for (int j = 0; j < 5; j++) begin
        chk1($sformatf("%s_valid_bpc%0d_c%0d", name, 1 << j, c), ov[j], (c >= (16 >> j)) ? 1'b1 : 1'b0);
        if (c == (16 >> j)) chk128($sformatf("%s_data_bpc%0d", name, 1 << j), od[j], exp);
      end
      in_data  = rnd128();
      in_valid = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    for (int j = 0; j < 5; j++) begin
      chk1($sformatf("%s_ready_after_bpc%0d", name, 1 << j), ir[j], 1'b1);
      chk1($sformatf("%s_valid_after_bpc%0d", name, 1 << j), ov[j], 1'b0);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] va, vb, held;
    logic [127:0] exp_q [$];
    int cyc, n_out, n_acc, xfer1, acc2;

    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_math(8'(i));
    in_valid = 1'b0; in_data = 128'h0; out_ready = 1'b0; rst_n = 1'b0;
    tick(); tick();
    for (int j = 0; j < 5; j++) begin
      chk1("rst_in_ready", ir[j], 1'b1);
      chk1("rst_out_valid", ov[j], 1'b0);
      chk1("rst_busy", bz[j], 1'b0);
      chk128("rst_out_data", od[j], 128'h0);
    end
    rst_n = 1'b1;
    tick();

    run_all("zero", 128'h0, 128'h63636363636363636363636363636363);
    run_all("fips", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
    run_all("order", 128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76);
    for (int r = 0; r < 3; r++) begin
      va = rnd128();
      run_all($sformatf("rand%0d", r), va, ref_sub(va));
    end

    // Asynchronous reset in the middle of BUSY with the zero state loaded.
    in_valid = 1'b1; in_data = 128'h0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk1("midbusy_busy_before", bz[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_out_valid", ov[0], 1'b0);
    chk1("midrst_busy", bz[0], 1'b0);
    chk1("midrst_in_ready", ir[0], 1'b1);
    chk128("midrst_out_data", od[0], 128'h0);
    in_valid = 1'b1; in_data = rnd128();
    tick();
    chk1("rst_handshake_ignored", bz[0], 1'b0);
    in_valid = 1'b0; rst_n = 1'b1;
    tick();

    // Backpressure: DONE held with out_ready low while inputs toggle.
    va = rnd128();
    in_valid = 1'b1; in_data = va;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 16; c++) tick();
    held = ref_sub(va);
    for (int c = 0; c < 10; c++) begin
      in_valid = ~in_valid; in_data = rnd128();
      tick();
      chk128($sformatf("bp_data_c%0d", c), od[0], held);
      chk1($sformatf("bp_in_ready_c%0d", c), ir[0], 1'b0);
      chk1($sformatf("bp_out_valid_c%0d", c), ov[0], 1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk1("bp_release_in_ready", ir[0], 1'b1);
    chk1("bp_release_busy", bz[0], 1'b0);
    reset_all();

    // Back-to-back on the one-byte-per-cycle instance.
    va = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    vb = 128'h000102030405060708090a0b0c0d0e0f;
    exp_q = {128'hd42711aee0bf98f1b8b45de51e415230, 128'h637c777bf26b6fc53001672bfed7ab76};
    in_valid = 1'b1; in_data = va; out_ready = 1'b1;
    tick();
    in_data = vb;
    cyc = 0; n_out = 0; n_acc = 1; xfer1 = -1; acc2 = -1;
    while (n_out < 2 && cyc < 100) begin
      if (ov[0]) begin
        chk128($sformatf("b2b_out%0d", n_out), od[0], exp_q[n_out]);
        if (n_out == 0) xfer1 = cyc;
        n_out++;
      end
      if (ir[0] && n_acc == 1) begin
        acc2 = cyc;
        n_acc++;
      end
      tick();
      cyc++;
      if (n_acc == 2) in_data = rnd128();
    end
    in_valid = 1'b0;
    chk1("b2b_two_outputs", (n_out == 2) ? 1'b1 : 1'b0, 1'b1);
    chk1("b2b_first_latency", (xfer1 == 16) ? 1'b1 : 1'b0, 1'b1);
    chk1("b2b_accept_gap", (acc2 == xfer1 + 1) ? 1'b1 : 1'b0, 1'b1);
    reset_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
